ahb_arbiter: RTL

- Round-robin bus arbiter sharing the AHB address/data bus among NO_OF_MASTERS masters.
- Drives HGRANT and HMASTER into the master-side mux. Tracks fixed-length bursts (INCR4/8/16, WRAP4/8/16) so ownership never changes mid-burst.
- Parks the bus on a default master when there are no requests.

---
 rtl/ahb_arbiter_if.sv | 34 +++
 rtl/ahb_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: bus-side signal bundle for the AHB round-robin arbiter.
// The master modport is the requesting side (masters plus the muxed
// address-phase controls). The slave modport is the arbiter itself.
// dbg_state / dbg_beat_cnt expose the arbiter FSM so checkers can bind to it.
//
// Handshake: there is no valid/ready pair here. A phase is "accepted" on a
// HCLK rise with HREADY=1. Every arbiter state change, and every output
// change outside reset, happens only on such an accepted edge.
interface ahb_arbiter_if #(
   parameter int NO_OF_MASTERS = 2,
   parameter int MW            = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1
);
   logic [NO_OF_MASTERS-1:0] HBUSREQ;
   logic [NO_OF_MASTERS-1:0] HLOCK;
   logic [1:0]               HTRANS;
   logic [2:0]               HBURST;
   logic                     HREADY;
   logic [NO_OF_MASTERS-1:0] HGRANT;
   logic [MW-1:0]            HMASTER;
   logic                     HMASTLOCK;
   // FSM visibility: 0 = ARB, 1 = BURST; remaining beats of a fixed burst
   logic                     dbg_state;
   logic [3:0]               dbg_beat_cnt;

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      input  HGRANT, HMASTER, HMASTLOCK, dbg_state, dbg_beat_cnt
   );

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      output HGRANT, HMASTER, HMASTLOCK, dbg_state, dbg_beat_cnt
   );
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with fixed-length burst tracking.
// - Grants rotate among requesters starting one past the current grant owner.
// - INCR4/8/16 and WRAP4/8/16 bursts hold the grant until the last beat is
//   accepted; an IDLE inside a burst ends it early.
// - With no requests the bus parks on DEFAULT_MASTER.
// Optional feature macro: AHB_ARB_HLOCK_EN
//   defined   -> HLOCK of the grant owner pins the grant; HMASTLOCK follows it.
//   undefined -> HLOCK ignored, HMASTLOCK tied low.
module ahb_arbiter #(
   parameter int NO_OF_MASTERS  = 2,
   parameter int DEFAULT_MASTER = 0,
   parameter int MW             = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1
) (
   input logic          HCLK,
   input logic          HRESETn,
   ahb_arbiter_if.slave bus
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [MW-1:0]            DEF_IDX   = MW'(DEFAULT_MASTER);
   localparam logic [NO_OF_MASTERS-1:0] DEF_GRANT = NO_OF_MASTERS'(1) << DEFAULT_MASTER;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   state_e                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [MW-1:0]            rr_ptr_q, rr_ptr_d;
   logic [NO_OF_MASTERS-1:0] grant_q, grant_d;
   logic [MW-1:0]            master_q, master_d;
   logic                     mastlock_q, mastlock_d;

   logic [MW-1:0]            rr_winner;
   logic                     owner_locked;
   logic [3:0]               burst_beats;

   // Beats remaining after the NONSEQ for a fixed-length burst; 0 means
   // the burst type does not pin the grant (SINGLE or undefined INCR).
   function automatic logic [3:0] fixed_burst_len(input logic [2:0] hburst);
      logic [3:0] len;
      case (hburst)
         3'b010, 3'b011: len = 4'd3;   // WRAP4 / INCR4
         3'b100, 3'b101: len = 4'd7;   // WRAP8 / INCR8
         3'b110, 3'b111: len = 4'd15;  // WRAP16 / INCR16
         default:        len = 4'd0;   // SINGLE / INCR
      endcase
      return len;
   endfunction

   assign burst_beats = fixed_burst_len(bus.HBURST);

`ifdef AHB_ARB_HLOCK_EN
   // The grant owner is the index held in rr_ptr_q (it mirrors HGRANT).
   assign owner_locked = bus.HLOCK[rr_ptr_q];
`else
   logic unused_hlock;
   assign unused_hlock = ^bus.HLOCK;
   assign owner_locked = 1'b0;
`endif

   // Round-robin search starting one past the current owner; the owner itself
   // is the last candidate so a lone requester keeps the bus. No request parks.
   always_comb begin
      logic [MW:0] cand;
      logic        found;
      rr_winner = DEF_IDX;
      found     = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NO_OF_MASTERS; i++) begin
         cand = {1'b0, rr_ptr_q} + (MW+1)'(i);
         if (cand >= (MW+1)'(NO_OF_MASTERS)) begin
            cand = cand - (MW+1)'(NO_OF_MASTERS);
         end
         if (!found && bus.HBUSREQ[cand[MW-1:0]]) begin
            found     = 1'b1;
            rr_winner = cand[MW-1:0];
         end
      end
   end

   // Next-state and next-output logic; everything holds unless HREADY=1.
   always_comb begin
      logic do_rearb;
      state_d    = state_q;
      cnt_d      = cnt_q;
      rr_ptr_d   = rr_ptr_q;
      master_d   = master_q;
      mastlock_d = mastlock_q;
      do_rearb   = 1'b0;

      if (bus.HREADY) begin
         // Address-phase ownership follows the grant one accepted phase later.
         master_d   = rr_ptr_q;
         mastlock_d = owner_locked;

         case (state_q)
            ST_ARB: begin
               if (bus.HTRANS == TR_NONSEQ && burst_beats != 4'd0) begin
                  cnt_d   = burst_beats;
                  state_d = ST_BURST;
               end else begin
                  do_rearb = 1'b1;
               end
            end
            ST_BURST: begin
               case (bus.HTRANS)
                  TR_SEQ: begin
                     // Last beat accepted: the next owner sees its grant now,
                     // overlapping the final data phase of this burst.
                     if (cnt_q <= 4'd1) begin
                        cnt_d    = 4'd0;
                        state_d  = ST_ARB;
                        do_rearb = 1'b1;
                     end else begin
                        cnt_d = cnt_q - 4'd1;
                     end
                  end
                  TR_BUSY: begin
                     // Owner is stalling inside the burst; keep everything.
                  end
                  TR_IDLE: begin
                     // Early termination of the burst.
                     cnt_d    = 4'd0;
                     state_d  = ST_ARB;
                     do_rearb = 1'b1;
                  end
                  default: begin
                     // NONSEQ: owner chains a new transfer without releasing.
                     if (burst_beats != 4'd0) begin
                        cnt_d = burst_beats;
                     end else begin
                        cnt_d    = 4'd0;
                        state_d  = ST_ARB;
                        do_rearb = 1'b1;
                     end
                  end
               endcase
            end
            default: begin
               state_d = ST_ARB;
               cnt_d   = 4'd0;
            end
         endcase

         if (do_rearb) begin
            rr_ptr_d = owner_locked ? rr_ptr_q : rr_winner;
         end
      end

      grant_d = NO_OF_MASTERS'(1) << rr_ptr_d;
   end

   // State and output registers; async reset parks on DEFAULT_MASTER.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_ARB;
         cnt_q      <= 4'd0;
         rr_ptr_q   <= DEF_IDX;
         grant_q    <= DEF_GRANT;
         master_q   <= DEF_IDX;
         mastlock_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         master_q   <= master_d;
         mastlock_q <= mastlock_d;
      end
   end

   assign bus.HGRANT       = grant_q;
   assign bus.HMASTER      = master_q;
   assign bus.HMASTLOCK    = mastlock_q;
   assign bus.dbg_state    = state_q;
   assign bus.dbg_beat_cnt = cnt_q;

   // The grant vector is a pure function of rr_ptr_q and must stay one-hot.
   a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot(grant_q));

   // Outside a burst the beat counter is always cleared.
   a_cnt_idle: assert property (@(posedge HCLK) disable iff (!HRESETn)
                                (state_q == ST_ARB) |-> (cnt_q == 4'd0));

endmodule
